instr_decoder: RTL and testbench
================================

Name: instr_decoder

Overview:
- Instruction register plus microcode decoder for the 8-bit SAP datapath.
- Latches the instruction word from the bus at the end of the fetch sequence and reports the instruction length (steps_required) back to the sequencer.
- During execute it drives the per-step datapath control lines from the latched opcode, the current step and its internal carry/zero flag register.
- Owns the sticky halt and illegal-opcode status.

Parameters:
- DATA_WIDTH, 8, bus / instruction width.
- ADDR_WIDTH, 4, operand (RAM address) width. DATA_WIDTH-ADDR_WIDTH must equal 4 (opcode field).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- bus_in  in  DATA_WIDTH  shared bus value
- ir_load  in  1  sequencer's in_bus strobe; IR captures bus_in at posedge
- exec_en  in  1  high while sequencer is in execute phase (inverse of its fetch flag)
- step  in  2  current execute step from sequencer
- alu_carry  in  1  ALU carry result
- alu_zero  in  1  ALU zero result
- steps_required  out  2  last step index of current instruction
- bus_out  out  DATA_WIDTH  {0, operand}; valid when ir_out=1
- ir_out, mar_load, ram_read, ram_write, a_load, a_out, b_load, alu_out, alu_sub, pc_load, out_load, flags_load  out  1 each  datapath controls
- halted  out  1  sticky halt
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: ir=0x00 (NOP), carry=0, zero=0, halted=0, illegal=0. All control outputs 0, steps_required=0, bus_out=0.
- IR: ir<=bus_in at posedge when ir_load=1. Controls in that same cycle decode the old IR. opcode=ir[7:4], operand=ir[3:0].
- Controls are combinational from (ir, step, flags, halted), all forced 0 unless exec_en=1 and halted=0.
- steps_required is combinational from opcode and is always valid.
- Step semantics: execute covers steps 0..steps_required. A step value above steps_required produces no controls.
- Microcode (op: steps_required; per-step controls):
  - 0x0 NOP: 0; none.
  - 0x1 LDA: 1; s0 ir_out+mar_load; s1 ram_read+a_load.
  - 0x2 ADD: 2; s0 ir_out+mar_load; s1 ram_read+b_load; s2 alu_out+a_load+flags_load, alu_sub=0.
  - 0x3 SUB: as ADD, with alu_sub=1 in s2.
  - 0x4 STA: 1; s0 ir_out+mar_load; s1 a_out+ram_write.
  - 0x5 LDI: 0; s0 ir_out+a_load.
  - 0x6 JMP: 0; s0 ir_out+pc_load.
  - 0x7 JC: 0; s0 ir_out, pc_load=carry.
  - 0x8 JZ: 0; s0 ir_out, pc_load=zero.
  - 0xE OUT: 0; s0 a_out+out_load.
  - 0xF HLT: 0; s0 none; halted<=1 at the posedge ending s0.
  - 0x9-0xD illegal: 0; no controls; illegal<=1 at the posedge ending s0.
- Flags: at posedge where the internal flags_load=1, carry<=alu_carry and zero<=alu_zero. Otherwise they hold. JC/JZ use the registered flags, i.e. the result of the last ADD/SUB.
- Halted: once set, holds until rst. It gates all controls but does not block ir_load. illegal also holds until rst.
- Single-driver rule: at most one of ir_out, a_out, alu_out, ram_read is high in any cycle.
- Reset mid-execute: everything returns to reset values immediately (asynchronous), including combinational outputs.

Optional Feature:
- Macro: DECODER_ILLEGAL_HALT_EN.
  - Defined: an illegal opcode also sets halted at the same edge that sets illegal.
  - Undefined: an illegal opcode behaves as NOP apart from setting illegal.

Test Plan:
- Reset, then bus_in=0x1A with ir_load=1 → steps_required=1. exec_en=1: step0 gives ir_out=1, mar_load=1, bus_out=0x0A; step1 gives ram_read=1, a_load=1.
- ADD 0x23 with alu_carry=1, alu_zero=0 at step2 → flags_load=1 at step2. Next JC 0x75 at step0 gives pc_load=1, bus_out=0x05. JZ 0x85 gives pc_load=0.
- SUB 0x31 → alu_sub=1 only in step2. Step value 3 produces all controls 0.
- HLT 0xF0, step0 edge → halted=1. Later LDI 0x57 with exec_en=1 gives all controls 0, while ir still loads 0x57.
- Opcode 0xA0 → illegal=1, steps_required=0. halted=1 only when DECODER_ILLEGAL_HALT_EN is defined.
- Assert rst during ADD step1 → ir=0, all outputs 0 in the same cycle, flags cleared.

Source files
------------

// File: rtl/instr_decoder_if.sv
// Decoder-side bundle between the SAP sequencer/datapath and instr_decoder.
// The master modport is the sequencer/datapath side; slave is the decoder.
interface instr_decoder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] bus_in;
    logic                  ir_load;
    logic                  exec_en;
    logic [1:0]            step;
    logic                  alu_carry;
    logic                  alu_zero;
    logic [1:0]            steps_required;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  ir_out;
    logic                  mar_load;
    logic                  ram_read;
    logic                  ram_write;
    logic                  a_load;
    logic                  a_out;
    logic                  b_load;
    logic                  alu_out;
    logic                  alu_sub;
    logic                  pc_load;
    logic                  out_load;
    logic                  flags_load;
    logic                  halted;
    logic                  illegal;

    modport master (
        output bus_in, ir_load, exec_en, step, alu_carry, alu_zero,
        input  steps_required, bus_out, ir_out, mar_load, ram_read, ram_write,
               a_load, a_out, b_load, alu_out, alu_sub, pc_load, out_load,
               flags_load, halted, illegal
    );

    modport slave (
        input  bus_in, ir_load, exec_en, step, alu_carry, alu_zero,
        output steps_required, bus_out, ir_out, mar_load, ram_read, ram_write,
               a_load, a_out, b_load, alu_out, alu_sub, pc_load, out_load,
               flags_load, halted, illegal
    );
endinterface

// File: rtl/instr_decoder.sv
// SAP instruction register + microcode decoder with sticky halt/illegal status.
// Optional macro DECODER_ILLEGAL_HALT_EN: an illegal opcode also sets halted.
module instr_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    instr_decoder_if.slave  dec
);
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [DATA_WIDTH-1:0] ir_r;
    logic                  carry_r;
    logic                  zero_r;
    logic                  halted_r;
    logic                  illegal_r;

    logic [3:0]            opcode_s;
    logic [ADDR_WIDTH-1:0] operand_s;
    logic [1:0]            steps_s;
    logic                  active_s;
    logic                  ir_out_s, mar_load_s, ram_read_s, ram_write_s;
    logic                  a_load_s, a_out_s, b_load_s, alu_out_s, alu_sub_s;
    logic                  pc_load_s, out_load_s, flags_load_s;
    logic                  hlt_set_s, ill_set_s, is_illegal_s;

    assign opcode_s     = ir_r[DATA_WIDTH-1:ADDR_WIDTH];
    assign operand_s    = ir_r[ADDR_WIDTH-1:0];
    assign is_illegal_s = (opcode_s >= 4'h9) && (opcode_s <= 4'hD);

    // Instruction length lookup; every opcode not listed is a single step.
    always_comb begin
        steps_s = 2'd0;
        case (opcode_s)
            OP_LDA, OP_STA: steps_s = 2'd1;
            OP_ADD, OP_SUB: steps_s = 2'd2;
            default:        steps_s = 2'd0;
        endcase
    end

    // Steps past the instruction length, or a halted core, drive nothing.
    assign active_s  = dec.exec_en && !halted_r && (dec.step <= steps_s);
    assign hlt_set_s = active_s && (dec.step == 2'd0) && (opcode_s == OP_HLT);
    assign ill_set_s = active_s && (dec.step == 2'd0) && is_illegal_s;

    // Per-step microcode for the latched opcode.
    always_comb begin
        ir_out_s     = 1'b0;
        mar_load_s   = 1'b0;
        ram_read_s   = 1'b0;
        ram_write_s  = 1'b0;
        a_load_s     = 1'b0;
        a_out_s      = 1'b0;
        b_load_s     = 1'b0;
        alu_out_s    = 1'b0;
        alu_sub_s    = 1'b0;
        pc_load_s    = 1'b0;
        out_load_s   = 1'b0;
        flags_load_s = 1'b0;
        if (active_s) begin
            case (opcode_s)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    case (dec.step)
                        2'd0: begin
                            ir_out_s   = 1'b1;
                            mar_load_s = 1'b1;
                        end
                        2'd1: begin
                            if (opcode_s == OP_STA) begin
                                a_out_s     = 1'b1;
                                ram_write_s = 1'b1;
                            end else begin
                                ram_read_s = 1'b1;
                                a_load_s   = (opcode_s == OP_LDA);
                                b_load_s   = (opcode_s != OP_LDA);
                            end
                        end
                        2'd2: begin
                            alu_out_s    = 1'b1;
                            a_load_s     = 1'b1;
                            flags_load_s = 1'b1;
                            alu_sub_s    = (opcode_s == OP_SUB);
                        end
                        default: ir_out_s = 1'b0;
                    endcase
                end
                OP_LDI: begin
                    ir_out_s = 1'b1;
                    a_load_s = 1'b1;
                end
                OP_JMP: begin
                    ir_out_s  = 1'b1;
                    pc_load_s = 1'b1;
                end
                OP_JC: begin
                    ir_out_s  = 1'b1;
                    pc_load_s = carry_r;
                end
                OP_JZ: begin
                    ir_out_s  = 1'b1;
                    pc_load_s = zero_r;
                end
                OP_OUT: begin
                    a_out_s    = 1'b1;
                    out_load_s = 1'b1;
                end
                default: ir_out_s = 1'b0;
            endcase
        end else begin
            ir_out_s = 1'b0;
        end
    end

    // Instruction register, ALU flags and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r      <= {DATA_WIDTH{1'b0}};
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            if (dec.ir_load) begin
                ir_r <= dec.bus_in;
            end
            if (flags_load_s) begin
                carry_r <= dec.alu_carry;
                zero_r  <= dec.alu_zero;
            end
            if (hlt_set_s) begin
                halted_r <= 1'b1;
            end
`ifdef DECODER_ILLEGAL_HALT_EN
            if (ill_set_s) begin
                halted_r <= 1'b1;
            end
`endif
            if (ill_set_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

    assign dec.steps_required = steps_s;
    assign dec.bus_out    = ir_out_s ? {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand_s}
                                     : {DATA_WIDTH{1'b0}};
    assign dec.ir_out     = ir_out_s;
    assign dec.mar_load   = mar_load_s;
    assign dec.ram_read   = ram_read_s;
    assign dec.ram_write  = ram_write_s;
    assign dec.a_load     = a_load_s;
    assign dec.a_out      = a_out_s;
    assign dec.b_load     = b_load_s;
    assign dec.alu_out    = alu_out_s;
    assign dec.alu_sub    = alu_sub_s;
    assign dec.pc_load    = pc_load_s;
    assign dec.out_load   = out_load_s;
    assign dec.flags_load = flags_load_s;
    assign dec.halted     = halted_r;
    assign dec.illegal    = illegal_r;
endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: directed microcode walk, then random
// traffic checked against a table-driven reference model.
module tb_instr_decoder;
    logic clk;
    logic rst;

    instr_decoder_if #(.DATA_WIDTH(8)) dec_if ();

    instr_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .dec (dec_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector bit masks: ir_out..flags_load, MSB first.
    localparam logic [11:0] M_IR  = 12'h800, M_MAR = 12'h400, M_RR  = 12'h200;
    localparam logic [11:0] M_RW  = 12'h100, M_AL  = 12'h080, M_AO  = 12'h040;
    localparam logic [11:0] M_BL  = 12'h020, M_ALU = 12'h010, M_SUB = 12'h008;
    localparam logic [11:0] M_PC  = 12'h004, M_OUT = 12'h002, M_FL  = 12'h001;

    typedef struct packed {
        logic [11:0] ctl;
        logic [1:0]  steps;
        logic [7:0]  bus;
        logic        halted;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] ctl_tab [16][4];
    int          steps_tab [16];

    logic [7:0]  m_ir;
    logic        m_carry, m_zero, m_halted, m_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_ir = 8'h00; m_carry = 1'b0; m_zero = 1'b0; m_halted = 1'b0; m_illegal = 1'b0;
    endfunction

    // One cycle: apply inputs, queue the expected outputs, advance the model.
    task automatic drive(input bit r, input logic [7:0] b, input bit ld, input bit en,
                         input logic [1:0] st, input bit c, input bit z);
        exp_t e;
        int   op;
        @(posedge clk);
        #1;
        rst = r;
        dec_if.bus_in = b; dec_if.ir_load = ld; dec_if.exec_en = en;
        dec_if.step = st; dec_if.alu_carry = c; dec_if.alu_zero = z;
        #1;
        if (r) model_reset();
        op = int'(m_ir[7:4]);
        e.ctl = 12'h000;
        if (en && !m_halted && int'(st) <= steps_tab[op]) begin
            e.ctl = ctl_tab[op][st];
            if (op == 7 && m_carry) e.ctl = e.ctl | M_PC;
            if (op == 8 && m_zero)  e.ctl = e.ctl | M_PC;
        end
        e.steps   = 2'(steps_tab[op]);
        e.bus     = (e.ctl & M_IR) != 12'h000 ? {4'h0, m_ir[3:0]} : 8'h00;
        e.halted  = m_halted;
        e.illegal = m_illegal;
        exp_q.push_back(e);
        if (!r) begin
            if (en && !m_halted && st == 2'd0) begin
                if (op == 15) m_halted = 1'b1;
                if (op >= 9 && op <= 13) begin
                    m_illegal = 1'b1;
`ifdef DECODER_ILLEGAL_HALT_EN
                    m_halted = 1'b1;
`endif
                end
            end
            if ((e.ctl & M_FL) != 12'h000) begin
                m_carry = c;
                m_zero  = z;
            end
            if (ld) m_ir = b;
        end
    endtask

    task automatic load(input logic [7:0] b);
        drive(1'b0, b, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic exec(input logic [1:0] st, input bit c, input bit z);
        drive(1'b0, 8'h00, 1'b0, 1'b1, st, c, z);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] got_ctl;
        int          drivers;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_ctl = {dec_if.ir_out, dec_if.mar_load, dec_if.ram_read, dec_if.ram_write,
                       dec_if.a_load, dec_if.a_out, dec_if.b_load, dec_if.alu_out,
                       dec_if.alu_sub, dec_if.pc_load, dec_if.out_load, dec_if.flags_load};
            check("controls", 32'(got_ctl), 32'(e.ctl));
            check("steps_required", 32'(dec_if.steps_required), 32'(e.steps));
            check("bus_out", 32'(dec_if.bus_out), 32'(e.bus));
            check("halted", 32'(dec_if.halted), 32'(e.halted));
            check("illegal", 32'(dec_if.illegal), 32'(e.illegal));
            drivers = int'(dec_if.ir_out) + int'(dec_if.a_out) + int'(dec_if.alu_out)
                    + int'(dec_if.ram_read);
            check("single_driver", 32'(drivers > 1), 32'(0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int o = 0; o < 16; o++) begin
            steps_tab[o] = 0;
            for (int s = 0; s < 4; s++) ctl_tab[o][s] = 12'h000;
        end
        steps_tab[1] = 1; steps_tab[2] = 2; steps_tab[3] = 2; steps_tab[4] = 1;
        ctl_tab[1][0] = M_IR | M_MAR;  ctl_tab[1][1] = M_RR | M_AL;
        ctl_tab[2][0] = M_IR | M_MAR;  ctl_tab[2][1] = M_RR | M_BL;
        ctl_tab[2][2] = M_ALU | M_AL | M_FL;
        ctl_tab[3][0] = M_IR | M_MAR;  ctl_tab[3][1] = M_RR | M_BL;
        ctl_tab[3][2] = M_ALU | M_AL | M_FL | M_SUB;
        ctl_tab[4][0] = M_IR | M_MAR;  ctl_tab[4][1] = M_AO | M_RW;
        ctl_tab[5][0] = M_IR | M_AL;
        ctl_tab[6][0] = M_IR | M_PC;
        ctl_tab[7][0] = M_IR;
        ctl_tab[8][0] = M_IR;
        ctl_tab[14][0] = M_AO | M_OUT;

        rst = 1'b1;
        dec_if.bus_in = 8'h00; dec_if.ir_load = 1'b0; dec_if.exec_en = 1'b0;
        dec_if.step = 2'd0; dec_if.alu_carry = 1'b0; dec_if.alu_zero = 1'b0;
        model_reset();

        // Reset state, then LDA 0x1A
        drive(1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        load(8'h1A); exec(2'd0, 1'b0, 1'b0); exec(2'd1, 1'b0, 1'b0);
        // ADD sets carry, then JC taken / JZ not taken
        load(8'h23); exec(2'd0, 1'b1, 1'b0); exec(2'd1, 1'b1, 1'b0); exec(2'd2, 1'b1, 1'b0);
        load(8'h75); exec(2'd0, 1'b0, 1'b1);
        load(8'h85); exec(2'd0, 1'b0, 1'b1);
        // SUB including the out-of-range step 3
        load(8'h31);
        for (int s = 0; s < 4; s++) exec(2'(s), 1'b0, 1'b1);
        load(8'h85); exec(2'd0, 1'b0, 1'b0);
        load(8'h4C); exec(2'd0, 1'b0, 1'b0); exec(2'd1, 1'b0, 1'b0); exec(2'd2, 1'b0, 1'b0);
        load(8'hE0); exec(2'd0, 1'b0, 1'b0);
        load(8'h63); exec(2'd0, 1'b0, 1'b0);
        // Illegal opcode
        load(8'hA0); exec(2'd0, 1'b0, 1'b0); exec(2'd0, 1'b0, 1'b0);
        // HLT, then controls are gated while IR keeps loading
        load(8'hF0); exec(2'd0, 1'b0, 1'b0);
        load(8'h57); exec(2'd0, 1'b0, 1'b0);
        load(8'h23); exec(2'd0, 1'b0, 1'b0);
        // Reset mid-ADD step1
        drive(1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        load(8'h23); exec(2'd0, 1'b1, 1'b1); exec(2'd1, 1'b1, 1'b1); exec(2'd2, 1'b1, 1'b1);
        load(8'h21); exec(2'd0, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        load(8'h75); exec(2'd0, 1'b0, 1'b0);
        load(8'h85); exec(2'd0, 1'b0, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 39) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
